imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory port: receives a program as a byte stream (valid/ready),
//  packs bytes into 16-bit instruction words and writes them to instruction memory from address 0.
//  Holds the processor stalled (cpu_hold) while loading. Sits between the host byte link and imem.
// PARAMETERS
//  ADDR_W  10    imem address width (matches 10-bit pc)
//  DATA_W  16    instruction width; only 16 is supported
//  DEPTH   1024  max words accepted; must be <= 2**ADDR_W
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       begin a load; sampled only in IDLE, DONE, ERR
//  byte_valid  in   1       host byte available
//  byte_data   in   8       host byte
//  byte_ready  out  1       loader accepts byte this cycle
//  imem_we     out  1       one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_W  write address
//  imem_wdata  out  DATA_W  write data
//  cpu_hold    out  1       processor stall; top ORs it into processor reset
//  done        out  1       level: last load completed OK
//  error       out  1       level: last load failed
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; address counter, word counter and checksum 0.
//  - Byte transfer occurs on a rising edge with byte_valid & byte_ready.
//  - byte_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 elsewhere (IDLE, FIN, DONE, ERR).
//  - Stream format: 2-byte word count N (big-endian), then N words, each high byte first.
//  - FSM: IDLE -start-> LEN_HI -> LEN_LO -> (N==0 or N>DEPTH ? ERR : DATA_HI) -> DATA_LO ->
//    (more words ? DATA_HI : FIN, or CHECK when CHECKSUM_EN) ; FIN -> DONE (one cycle).
//  - start in DONE/ERR clears done/error and enters LEN_HI; start in any other state is ignored.
//  - cpu_hold: 1 in every state except IDLE and DONE; stays 1 in ERR until start or reset.
//  - Write timing: when the low byte of word k is accepted at edge E, imem_we=1 for exactly the
//    cycle after E, with imem_addr=k and imem_wdata={hi,lo}; addr/wdata hold their value otherwise.
//    Address counter is ADDR_W bits, starts at 0, increments after each write; no wrap possible
//    because N <= DEPTH is enforced.
//  - Back-to-back bytes accepted every cycle; a write pulse may overlap acceptance of the next
//    word's high byte.
//  - done rises the cycle after the final imem_we (FIN->DONE), same edge cpu_hold falls.
//  - Word count 0 or > DEPTH: ERR on the edge accepting LEN_LO; no imem_we issued.
//  - Reset mid-load: immediate return to IDLE; partially loaded memory is not cleared.
//  - byte_valid while byte_ready=0: byte not consumed; host must hold it.
// CONFIGURATION
//  - CHECKSUM_EN defined: one extra byte follows the data = XOR of all 2N data bytes. State CHECK
//    (byte_ready=1) after the last DATA_LO; match -> DONE, mismatch -> ERR (writes already made
//    stay). The final word's imem_we occurs in the first CHECK cycle. done rises the edge after
//    the checksum byte is accepted.
//  - CHECKSUM_EN undefined: no checksum byte, no CHECK state, no accumulator logic.
// STRUCTURE
//  - Shared include loader_defs.vh: state encodings (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
//    CHECK, FIN, DONE, ERR, 4-bit), LOADER_BYTE_W=8.
//  - Single module; no sub-module needed (byte packing, counters, checksum inline).
// TESTING
//  1. start; bytes 00 03 4A 05 12 34 FF FF back-to-back -> imem_we at addr 0,1,2 with
//     4A05,1234,FFFF; done=1 one cycle after last write; cpu_hold 1->0 same edge.
//  2. Count 00 00 -> error=1, cpu_hold stays 1, no imem_we; start again -> error clears.
//  3. Count 04 01 (1025) -> error=1, no writes; byte_ready 0 in ERR.
//  4. byte_valid asserted every other cycle, N=2 words ABCD,0001 -> same writes addr 0,1, done.
//  5. reset after 5 bytes of a N=3 load -> all outputs 0 next cycle; new load of N=1 word 1111
//     -> written at addr 0.
//  6. CHECKSUM_EN, N=1 word 12 34, checksum 26 -> done; checksum 27 -> error, addr 0 still written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   - 4-bit FSM state encodings (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
//     CHECK, FIN, DONE, ERR)
//   - LOADER_BYTE_W: width of the host byte link
//   - rx_state(): states in which the loader accepts a host byte
package imem_loader_pkg;

  localparam int LOADER_BYTE_W = 8;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_FIN     = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  function automatic logic rx_state(input logic [3:0] s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory port.
// Receives a program over a valid/ready byte link: a big-endian 16-bit word
// count N followed by N words (high byte first). Each word is written to
// instruction memory starting at address 0. cpu_hold keeps the processor
// stalled while a load is in flight or after a failed load.
//
// Optional feature: define CHECKSUM_EN to expect one extra byte after the
// data (XOR of all 2N data bytes); mismatch ends the load in ERR.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERR only)
//   byte_valid/byte_data  host byte stream
//   byte_ready            byte accepted this cycle when also byte_valid
//   imem_we/addr/wdata    one-cycle write strobe with address and data
//   cpu_hold              processor stall
//   done, error           level status of the last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [LOADER_BYTE_W-1:0] byte_data,
  output logic                     byte_ready,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [DATA_W-1:0]        imem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  // 17 bits so DEPTH = 65536 would still compare correctly.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [3:0]               state;
  logic [LOADER_BYTE_W-1:0] len_hi;
  logic [LOADER_BYTE_W-1:0] hi_byte;
  logic [15:0]              len;
  logic [15:0]              word_cnt;
  logic [15:0]              n_rx;
  logic                     xfer;
  logic                     last_word;
`ifdef CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] cks;
`endif

  assign xfer      = byte_valid & byte_ready;
  assign n_rx      = {len_hi, byte_data};
  assign last_word = (word_cnt + 16'd1) == len;

  // Status outputs decode straight from state so they all change on the
  // same edge as the state transition.
  assign byte_ready = rx_state(state);
  assign cpu_hold   = !((state == S_IDLE) || (state == S_DONE));
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_hi     <= '0;
      hi_byte    <= '0;
      len        <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef CHECKSUM_EN
      cks        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            word_cnt <= '0;
`ifdef CHECKSUM_EN
            cks      <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len   <= n_rx;
            state <= ((n_rx == 16'd0) || ({1'b0, n_rx} > DEPTH_L)) ? S_ERR : S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
`ifdef CHECKSUM_EN
            cks     <= cks ^ byte_data;
`endif
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            // Write lands the cycle after the low byte; it may overlap
            // acceptance of the next word's high byte.
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'(word_cnt);
            imem_wdata <= DATA_W'({hi_byte, byte_data});
            word_cnt   <= word_cnt + 16'd1;
`ifdef CHECKSUM_EN
            cks        <= cks ^ byte_data;
            state      <= last_word ? S_CHECK : S_DATA_HI;
`else
            state      <= last_word ? S_FIN : S_DATA_HI;
`endif
          end
        end
`ifdef CHECKSUM_EN
        S_CHECK: begin
          if (xfer) state <= ((cks ^ byte_data) == '0) ? S_DONE : S_ERR;
        end
`endif
        S_FIN:   state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
